gpio_cmd_decoder: RTL and testbench

//  Consumes the one-cycle command strobe/word produced by the GPIO CDC bridge in the waveform clock domain.

---
 rtl/gpio_cmd_pkg.sv | 24 ++
 rtl/gpio_cmd_chan_regs.sv | 77 +++++++
 rtl/gpio_cmd_decoder.sv | 166 ++++++++++++++++
 tb/tb_gpio_cmd_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_cmd_pkg.sv
// Shared command-word constants for the GPIO command decoder.
// The same opcodes and field positions also feed the bridge-side software driver header.
package gpio_cmd_pkg;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_FREQ_LO = 4'd1;
    localparam logic [3:0] OP_FREQ_HI = 4'd2;
    localparam logic [3:0] OP_AMP     = 4'd3;
    localparam logic [3:0] OP_COMMIT  = 4'd4;
    localparam logic [3:0] OP_CLEAR   = 4'd5;

    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 28;
    localparam int unsigned CH_MSB   = 27;
    localparam int unsigned CH_LSB   = 24;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_HI = 1'b1
    } state_e;

endpackage

// File: rtl/gpio_cmd_chan_regs.sv
// One waveform channel: staged and active frequency/amplitude plus dirty flags.
// COMMIT moves only the dirty staged values to the active side.
module gpio_cmd_chan_regs
    import gpio_cmd_pkg::*;
#(
    parameter int unsigned AMP_W = 16
) (
    input  logic             dst_clk,
    input  logic             dst_rst_n,
    input  logic             freq_we,
    input  logic [31:0]      freq_wdata,
    input  logic             amp_we,
    input  logic [AMP_W-1:0] amp_wdata,
    input  logic             commit,
    input  logic             clear,
    output logic [31:0]      freq_active,
    output logic [AMP_W-1:0] amp_active,
    output logic             dirty
);

    logic [31:0]      freq_stage_q, freq_stage_d;
    logic [31:0]      freq_active_q, freq_active_d;
    logic             freq_dirty_q, freq_dirty_d;
    logic [AMP_W-1:0] amp_stage_q, amp_stage_d;
    logic [AMP_W-1:0] amp_active_q, amp_active_d;
    logic             amp_dirty_q, amp_dirty_d;

    always_comb begin
        freq_stage_d  = freq_stage_q;
        freq_active_d = freq_active_q;
        freq_dirty_d  = freq_dirty_q;
        amp_stage_d   = amp_stage_q;
        amp_active_d  = amp_active_q;
        amp_dirty_d   = amp_dirty_q;
        if (freq_we) begin
            freq_stage_d = freq_wdata;
            freq_dirty_d = 1'b1;
        end
        if (amp_we) begin
            amp_stage_d = amp_wdata;
            amp_dirty_d = 1'b1;
        end
        if (commit) begin
            if (freq_dirty_q) freq_active_d = freq_stage_q;
            if (amp_dirty_q)  amp_active_d  = amp_stage_q;
            freq_dirty_d = 1'b0;
            amp_dirty_d  = 1'b0;
        end
        if (clear) begin
            freq_dirty_d = 1'b0;
            amp_dirty_d  = 1'b0;
        end
    end

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            freq_stage_q  <= '0;
            freq_active_q <= '0;
            freq_dirty_q  <= 1'b0;
            amp_stage_q   <= '0;
            amp_active_q  <= '0;
            amp_dirty_q   <= 1'b0;
        end else begin
            freq_stage_q  <= freq_stage_d;
            freq_active_q <= freq_active_d;
            freq_dirty_q  <= freq_dirty_d;
            amp_stage_q   <= amp_stage_d;
            amp_active_q  <= amp_active_d;
            amp_dirty_q   <= amp_dirty_d;
        end
    end

    assign freq_active = freq_active_q;
    assign amp_active  = amp_active_q;
    assign dirty       = freq_dirty_q | amp_dirty_q;

endmodule

// File: rtl/gpio_cmd_decoder.sv
// Decodes bridge command words into per-channel staged registers with atomic COMMIT,
// a LO/HI frequency pairing sequencer and a saturating error counter.
module gpio_cmd_decoder
    import gpio_cmd_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned AMP_W = 16
) (
    input  logic                    dst_clk,
    input  logic                    dst_rst_n,
    input  logic                    gpio_wen,
    input  logic [31:0]             gpio_wdata,
    output logic [N_CH*32-1:0]      freq_active,
    output logic [N_CH*AMP_W-1:0]   amp_active,
    output logic                    commit_pulse,
    output logic [N_CH-1:0]         commit_mask,
    output logic                    err_pulse,
    output logic [15:0]             err_count,
    output logic                    busy
);

    logic [3:0]  op;
    logic [3:0]  ch;
    logic [15:0] data;
    logic        ch_ok;
    logic        unused_fields;

    assign op            = gpio_wdata[OP_MSB:OP_LSB];
    assign ch            = gpio_wdata[CH_MSB:CH_LSB];
    assign data          = gpio_wdata[DATA_MSB:DATA_LSB];
    assign ch_ok         = (32'(ch) < N_CH);
    assign unused_fields = ^gpio_wdata[23:16];

    state_e          state_q, state_d;
    logic [15:0]     lo_hold_q, lo_hold_d;
    logic [3:0]      lo_ch_q, lo_ch_d;
    logic            commit_pulse_q, commit_pulse_d;
    logic [N_CH-1:0] commit_mask_q, commit_mask_d;
    logic            err_pulse_q, err_pulse_d;
    logic [15:0]     err_count_q, err_count_d;

    logic [N_CH-1:0] ch_sel;
    logic [N_CH-1:0] freq_we;
    logic [N_CH-1:0] amp_we;
    logic [N_CH-1:0] dirty;
    logic            do_commit;
    logic            do_clear;
    logic            do_freq;
    logic            do_amp;
    logic            err;

    always_comb begin
        ch_sel = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_sel[i] = (32'(ch) == i);
        end
    end

    always_comb begin
        state_d   = state_q;
        lo_hold_d = lo_hold_q;
        lo_ch_d   = lo_ch_q;
        do_commit = 1'b0;
        do_clear  = 1'b0;
        do_freq   = 1'b0;
        do_amp    = 1'b0;
        err       = 1'b0;
        if (gpio_wen) begin
            case (op)
                OP_NOP: ;
                OP_FREQ_LO: begin
                    if (!ch_ok) begin
                        err = 1'b1;
                    end else begin
                        // A fresh LO while one is pending aborts the old pair but is itself kept.
                        err       = (state_q == ST_WAIT_HI);
                        lo_hold_d = data;
                        lo_ch_d   = ch;
                        state_d   = ST_WAIT_HI;
                    end
                end
                OP_FREQ_HI: begin
                    if (!ch_ok) begin
                        err = 1'b1;
                    end else if (state_q == ST_WAIT_HI && ch == lo_ch_q) begin
                        do_freq = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                OP_AMP: begin
                    if (!ch_ok) err = 1'b1;
                    else        do_amp = 1'b1;
                end
                OP_COMMIT: begin
                    do_commit = 1'b1;
                    if (state_q == ST_WAIT_HI) begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                OP_CLEAR: begin
                    do_clear = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: err = 1'b1;
            endcase
        end
    end

    always_comb begin
        freq_we        = do_freq ? ch_sel : '0;
        amp_we         = do_amp ? ch_sel : '0;
        commit_pulse_d = do_commit;
        commit_mask_d  = do_commit ? dirty : '0;
        err_pulse_d    = err;
        err_count_d    = (err && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
    end

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            state_q        <= ST_IDLE;
            lo_hold_q      <= '0;
            lo_ch_q        <= '0;
            commit_pulse_q <= 1'b0;
            commit_mask_q  <= '0;
            err_pulse_q    <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            lo_hold_q      <= lo_hold_d;
            lo_ch_q        <= lo_ch_d;
            commit_pulse_q <= commit_pulse_d;
            commit_mask_q  <= commit_mask_d;
            err_pulse_q    <= err_pulse_d;
            err_count_q    <= err_count_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        gpio_cmd_chan_regs #(
            .AMP_W(AMP_W)
        ) u_chan (
            .dst_clk     (dst_clk),
            .dst_rst_n   (dst_rst_n),
            .freq_we     (freq_we[g]),
            .freq_wdata  ({data, lo_hold_q}),
            .amp_we      (amp_we[g]),
            .amp_wdata   (data[AMP_W-1:0]),
            .commit      (do_commit),
            .clear       (do_clear),
            .freq_active (freq_active[g*32 +: 32]),
            .amp_active  (amp_active[g*AMP_W +: AMP_W]),
            .dirty       (dirty[g])
        );
    end

    assign commit_pulse = commit_pulse_q;
    assign commit_mask  = commit_mask_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;
    assign busy         = (state_q == ST_WAIT_HI);

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// Self-checking bench for gpio_cmd_decoder: vector table through a scoreboard queue,
// then saturation and mid-pair reset sequences.
module tb_gpio_cmd_decoder;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned AMP_W = 16;

    logic                  dst_clk = 1'b0;
    logic                  dst_rst_n;
    logic                  gpio_wen;
    logic [31:0]           gpio_wdata;
    logic [N_CH*32-1:0]    freq_active;
    logic [N_CH*AMP_W-1:0] amp_active;
    logic                  commit_pulse;
    logic [N_CH-1:0]       commit_mask;
    logic                  err_pulse;
    logic [15:0]           err_count;
    logic                  busy;

    gpio_cmd_decoder #(
        .N_CH (N_CH),
        .AMP_W(AMP_W)
    ) dut (
        .dst_clk     (dst_clk),
        .dst_rst_n   (dst_rst_n),
        .gpio_wen    (gpio_wen),
        .gpio_wdata  (gpio_wdata),
        .freq_active (freq_active),
        .amp_active  (amp_active),
        .commit_pulse(commit_pulse),
        .commit_mask (commit_mask),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 dst_clk = ~dst_clk;

    typedef struct {
        logic        wen;
        logic [3:0]  op;
        logic [3:0]  ch;
        logic [15:0] data;
        logic        cp;
        logic [3:0]  mask;
        logic        err;
        logic        busy;
    } vec_t;

    typedef struct {
        logic        cp;
        logic [3:0]  mask;
        logic        err;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_cnt = 16'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic wen, input logic [3:0] op, input logic [3:0] ch,
                               input logic [15:0] data, input logic cp, input logic [3:0] mask,
                               input logic err, input logic bsy);
        vec_t r;
        r.wen = wen; r.op = op; r.ch = ch; r.data = data;
        r.cp = cp; r.mask = mask; r.err = err; r.busy = bsy;
        return r;
    endfunction

    task automatic send(input vec_t t);
        exp_t e;
        if (t.err) model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
        e.cp = t.cp; e.mask = t.mask; e.err = t.err; e.busy = t.busy; e.cnt = model_cnt;
        sb.push_back(e);
        gpio_wen   = t.wen;
        gpio_wdata = {t.op, t.ch, 8'hA5, t.data};
        @(posedge dst_clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            check("commit_pulse", 128'(commit_pulse), 128'(e.cp));
            check("commit_mask",  128'(commit_mask),  128'(e.mask));
            check("err_pulse",    128'(err_pulse),    128'(e.err));
            check("busy",         128'(busy),         128'(e.busy));
            check("err_count",    128'(err_count),    128'(e.cnt));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        dst_rst_n  = 1'b0;
        gpio_wen   = 1'b0;
        gpio_wdata = '0;
        #12;
        check("rst_freq",  128'(freq_active), 128'(0));
        check("rst_amp",   128'(amp_active),  128'(0));
        check("rst_busy",  128'(busy),        128'(0));
        check("rst_count", 128'(err_count),   128'(0));
        @(negedge dst_clk);
        dst_rst_n = 1'b1;
        @(posedge dst_clk);
        #1;

        //             wen op     ch     data      cp mask     err busy
        tbl.push_back(v(1, 4'd1,  4'd1,  16'h5678, 0, 4'b0000, 0, 1));
        tbl.push_back(v(1, 4'd2,  4'd1,  16'h1234, 0, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd4,  4'd0,  16'h0000, 1, 4'b0010, 0, 0));
        tbl.push_back(v(1, 4'd3,  4'd0,  16'h00FF, 0, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd3,  4'd3,  16'h8000, 0, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd4,  4'd0,  16'h0000, 1, 4'b1001, 0, 0));
        tbl.push_back(v(1, 4'd4,  4'd0,  16'h0000, 1, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd2,  4'd2,  16'h1111, 0, 4'b0000, 1, 0));
        tbl.push_back(v(1, 4'd1,  4'd0,  16'hAAAA, 0, 4'b0000, 0, 1));
        tbl.push_back(v(1, 4'd2,  4'd2,  16'hBBBB, 0, 4'b0000, 1, 0));
        tbl.push_back(v(1, 4'd4,  4'd0,  16'h0000, 1, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd3,  4'd0,  16'h0011, 0, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd1,  4'd0,  16'h2222, 0, 4'b0000, 0, 1));
        tbl.push_back(v(1, 4'd4,  4'd0,  16'h0000, 1, 4'b0001, 1, 0));
        tbl.push_back(v(1, 4'd1,  4'd1,  16'h0001, 0, 4'b0000, 0, 1));
        tbl.push_back(v(1, 4'd9,  4'd0,  16'h0000, 0, 4'b0000, 1, 1));
        tbl.push_back(v(1, 4'd3,  4'd7,  16'h0000, 0, 4'b0000, 1, 1));
        tbl.push_back(v(1, 4'd0,  4'd0,  16'h0000, 0, 4'b0000, 0, 1));
        tbl.push_back(v(1, 4'd3,  4'd2,  16'h1234, 0, 4'b0000, 0, 1));
        tbl.push_back(v(1, 4'd2,  4'd7,  16'h0000, 0, 4'b0000, 1, 1));
        tbl.push_back(v(1, 4'd1,  4'd2,  16'h0002, 0, 4'b0000, 1, 1));
        tbl.push_back(v(1, 4'd2,  4'd2,  16'h0003, 0, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd5,  4'd0,  16'h0000, 0, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd4,  4'd0,  16'h0000, 1, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd1,  4'd3,  16'h4444, 0, 4'b0000, 0, 1));
        tbl.push_back(v(1, 4'd5,  4'd0,  16'h0000, 0, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd2,  4'd3,  16'h5555, 0, 4'b0000, 1, 0));
        tbl.push_back(v(1, 4'd15, 4'd0,  16'h0000, 0, 4'b0000, 1, 0));
        tbl.push_back(v(1, 4'd3,  4'd1,  16'h7777, 0, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'd4,  4'd1,  16'h0000, 0, 4'b0000, 0, 0));
        tbl.push_back(v(1, 4'd4,  4'd0,  16'h0000, 1, 4'b0010, 0, 0));
        tbl.push_back(v(0, 4'd0,  4'd0,  16'h0000, 0, 4'b0000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) send(tbl[i]);

        check("freq_ch0", 128'(freq_active[0*32 +: 32]), 128'(32'h0000_0000));
        check("freq_ch1", 128'(freq_active[1*32 +: 32]), 128'(32'h1234_5678));
        check("freq_ch2", 128'(freq_active[2*32 +: 32]), 128'(32'h0000_0000));
        check("freq_ch3", 128'(freq_active[3*32 +: 32]), 128'(32'h0000_0000));
        check("amp_ch0",  128'(amp_active[0*16 +: 16]),  128'(16'h0011));
        check("amp_ch1",  128'(amp_active[1*16 +: 16]),  128'(16'h7777));
        check("amp_ch2",  128'(amp_active[2*16 +: 16]),  128'(16'h0000));
        check("amp_ch3",  128'(amp_active[3*16 +: 16]),  128'(16'h8000));

        // Jump the counter near its ceiling instead of generating 65k errors.
        force dut.err_count_q = 16'hFFFE;
        #1;
        release dut.err_count_q;
        model_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) send(v(1, 4'd9, 4'd0, 16'h0000, 0, 4'b0000, 1, 0));
        send(v(0, 4'd0, 4'd0, 16'h0000, 0, 4'b0000, 0, 0));

        send(v(1, 4'd1, 4'd1, 16'h9999, 0, 4'b0000, 0, 1));
        gpio_wen = 1'b0;
        #2;
        dst_rst_n = 1'b0;
        #1;
        check("midrst_freq",  128'(freq_active),  128'(0));
        check("midrst_amp",   128'(amp_active),   128'(0));
        check("midrst_busy",  128'(busy),         128'(0));
        check("midrst_count", 128'(err_count),    128'(0));
        check("midrst_pulse", 128'({commit_pulse, commit_mask, err_pulse}), 128'(0));
        model_cnt = 16'd0;
        @(negedge dst_clk);
        dst_rst_n = 1'b1;
        @(posedge dst_clk);
        #1;
        send(v(1, 4'd2, 4'd1, 16'h8888, 0, 4'b0000, 1, 0));
        send(v(1, 4'd4, 4'd0, 16'h0000, 1, 4'b0000, 0, 0));
        check("post_rst_freq_ch1", 128'(freq_active[1*32 +: 32]), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
